alu_mc: RTL
===========

# alu_mc

Parametrised multi-cycle ALU: generalised successor to the 4-bit combinational ALU. Widens the datapath to `WIDTH` bits and adds signed compare, iterative multiply and unsigned divide/remainder. Operands enter and results leave through valid/ready handshakes with registered outputs. The block sits between the decode/operand-fetch stage and writeback of the NPC execute stage.

## Interface
- `WIDTH`, default 32: operand/result width; legal values are ≥4.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `in_valid`  in  1  operand/op request.
- `in_ready`  out  1  block can accept a request.
- `in_op`  in  4  opcode.
- `in_a`, `in_b`  in  WIDTH  operands.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer takes result.
- `out_res`  out  WIDTH  result.
- `out_zero`, `out_overflow`, `out_carry`, `out_illegal`  out  1 each  flags.

## Operation
- Opcodes:
  - 0 ADD; 1 SUB; 2 NOT a; 3 AND; 4 OR; 5 XOR.
  - 6 SLT, signed; 7 EQ; 8 SLTU, unsigned.
  - 9 MUL, low WIDTH bits; 10 DIVU; 11 REMU.
  - 12–15 illegal.
- SLT, EQ and SLTU produce `res` = 1 or 0, zero-extended.
- Flag rules:
  - `out_zero` = (res == 0) for every op, including illegal.
  - ADD: `carry` = bit WIDTH of a+b; `overflow` = signed overflow.
  - SUB: computed as a + ~b + 1. `carry` = carry-out, which is 1 iff a ≥ b unsigned; `overflow` = signed overflow.
  - MUL: `overflow` = upper WIDTH bits of the full 2·WIDTH product ≠ 0.
  - DIVU with b = 0: res = all ones, `overflow` = 1. REMU with b = 0: res = a, `overflow` = 1.
  - Illegal op: res = 0, `out_illegal` = 1, `zero` = 1.
  - All flags not listed above are 0.
- FSM states and transitions:
  - IDLE: `in_ready` = 1. On acceptance (`in_valid` && `in_ready`), the block latches op, a and b. Single-cycle ops go to DONE; ops 9–11 go to CALC.
  - CALC: one shift-add (MUL) or restoring-subtract (DIVU/REMU) step per cycle. A counter counts WIDTH steps, then the FSM goes to DONE.
  - DONE: `out_valid` = 1. On `out_ready`, the FSM returns to IDLE.
- `in_ready` is 0 in CALC and DONE. `in_valid` in those states is ignored; the request is not latched.
- Outputs are registers. They hold stable in DONE until the handshake completes.

## Timing
- Reset values:
  - FSM state = IDLE.
  - `in_ready` = 1.
  - `out_valid` = 0.
  - `out_res` = 0.
  - All flags = 0.
  - Counter = 0.
- Latency, counted from the acceptance edge:
  - Single-cycle ops: `out_valid` rises on the next edge (latency 1).
  - MUL/DIVU/REMU: `out_valid` rises WIDTH+1 edges after acceptance.
- Throughput:
  - One single-cycle op every 2 cycles when `out_ready` is held high.
  - No request overlap.
- Handshake: the earliest next acceptance is the cycle after the DONE→IDLE transition.
- Backpressure: DONE lasts indefinitely while `out_ready` = 0. No output bit changes during that time.
- Reset mid-operation (`rst` asserted in CALC or DONE):
  - The block returns to IDLE immediately and asynchronously.
  - The pending result is discarded; `out_valid` = 0.
- Counter width is $clog2(WIDTH+1). It does not wrap during a calculation.

## Structure
- `alu_pkg`: opcode localparams (`ALU_ADD` … `ALU_REMU`) and the FSM state enum (`S_IDLE`, `S_CALC`, `S_DONE`).
- Sub-module `alu_muldiv_iter`: holds the iterative MUL/DIVU/REMU datapath and the step counter. It has a start/done interface and is parametrised by `WIDTH`.
- The top level holds the FSM, the single-cycle op logic, the flag logic and the output registers.

## Test plan
- WIDTH=4, ADD 7+1 → res 8, `overflow` 1, `carry` 0, `zero` 0. `out_valid` is high exactly 1 cycle after acceptance.
- WIDTH=4, SUB 3−3 → res 0, `zero` 1, `carry` 1, `overflow` 0. SLT a=4'hF, b=1 → 1; SLTU on the same operands → 0.
- WIDTH=32, MUL 0x10000×0x10000 → res 0, `zero` 1, `overflow` 1. `out_valid` rises exactly 33 cycles after acceptance.
- WIDTH=32:
  - DIVU 100/7 → 14.
  - REMU 100/7 → 2.
  - DIVU 5/0 → 0xFFFFFFFF with `overflow` 1.
  - REMU 5/0 → 5 with `overflow` 1.
- Hold `out_ready` = 0 for 5 cycles in DONE → outputs stable and `in_ready` 0. An `in_valid` pulse during this time is ignored: no second result appears.
- Assert `rst` 10 cycles into a MUL → `out_valid` 0 and `in_ready` 1 after release. A following ADD 2+2 returns 4. Illegal op 13 → res 0, `out_illegal` 1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and flag payload for the multi-cycle ALU.
package alu_pkg;

  localparam int unsigned OP_W = 4;

  localparam logic [OP_W-1:0] ALU_ADD  = 4'd0;
  localparam logic [OP_W-1:0] ALU_SUB  = 4'd1;
  localparam logic [OP_W-1:0] ALU_NOT  = 4'd2;
  localparam logic [OP_W-1:0] ALU_AND  = 4'd3;
  localparam logic [OP_W-1:0] ALU_OR   = 4'd4;
  localparam logic [OP_W-1:0] ALU_XOR  = 4'd5;
  localparam logic [OP_W-1:0] ALU_SLT  = 4'd6;
  localparam logic [OP_W-1:0] ALU_EQ   = 4'd7;
  localparam logic [OP_W-1:0] ALU_SLTU = 4'd8;
  localparam logic [OP_W-1:0] ALU_MUL  = 4'd9;
  localparam logic [OP_W-1:0] ALU_DIVU = 4'd10;
  localparam logic [OP_W-1:0] ALU_REMU = 4'd11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic zero;
    logic overflow;
    logic carry;
    logic illegal;
  } alu_flags_t;

  function automatic logic is_muldiv(input logic [OP_W-1:0] op);
    return (op == ALU_MUL) || (op == ALU_DIVU) || (op == ALU_REMU);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider, one step per cycle.
// The first step is taken on the start edge, so WIDTH steps finish WIDTH-1 edges later.
module alu_muldiv_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done_c,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] hi_q, lo_q, b_q;
  logic             div_q, active_q;
  logic [CNT_W-1:0] cnt_q;

  logic [WIDTH-1:0] cur_hi, cur_lo, cur_b, nxt_hi, nxt_lo;
  logic             cur_div, step;
  logic [WIDTH:0]   mul_sum, div_shift, div_trial;

  // MUL: {hi,lo} shifts right with the partial sum; DIVU: hi is the remainder, lo the dividend/quotient.
  always_comb begin
    cur_hi    = start ? '0 : hi_q;
    cur_lo    = start ? a : lo_q;
    cur_b     = start ? b : b_q;
    cur_div   = start ? is_div : div_q;
    step      = start || (active_q && (cnt_q != CNT_W'(WIDTH)));
    mul_sum   = {1'b0, cur_hi} + (cur_lo[0] ? {1'b0, cur_b} : '0);
    div_shift = {cur_hi, cur_lo[WIDTH-1]};
    div_trial = div_shift - {1'b0, cur_b};
    if (cur_div) begin
      nxt_hi = div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
      nxt_lo = {cur_lo[WIDTH-2:0], ~div_trial[WIDTH]};
    end else begin
      nxt_hi = mul_sum[WIDTH:1];
      nxt_lo = {mul_sum[0], cur_lo[WIDTH-1:1]};
    end
  end

  assign done_c = active_q && (cnt_q == CNT_W'(WIDTH));
  assign hi     = hi_q;
  assign lo     = lo_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q     <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      div_q    <= 1'b0;
      active_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (start) begin
        b_q      <= b;
        div_q    <= is_div;
        active_q <= 1'b1;
        cnt_q    <= CNT_W'(1);
      end else if (step) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end else if (done_c) begin
        active_q <= 1'b0;
      end
      if (step) begin
        hi_q <= nxt_hi;
        lo_q <= nxt_lo;
      end
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: valid/ready in, registered result and flags out; MUL/DIVU/REMU run iteratively.
module alu_mc
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_zero,
  output logic             out_overflow,
  output logic             out_carry,
  output logic             out_illegal
);

  localparam int unsigned WP1 = WIDTH + 1;

  state_t           state_q, state_d;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  alu_flags_t       flags_q, flags_d, s_flags, m_flags;
  logic [WIDTH-1:0] res_d, s_res, m_res;
  logic             valid_d, ready_d;
  logic             accept, start, done_c;
  logic [WIDTH-1:0] md_hi, md_lo;
  logic [WIDTH:0]   add_sum, sub_sum;

  assign accept = (state_q == S_IDLE) && in_valid;
  assign start  = accept && is_muldiv(in_op);

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .is_div (in_op != ALU_MUL),
    .a      (in_a),
    .b      (in_b),
    .done_c (done_c),
    .hi     (md_hi),
    .lo     (md_lo)
  );

  // Single-cycle ops evaluate straight from the request so they retire on the acceptance edge.
  always_comb begin
    add_sum = {1'b0, in_a} + {1'b0, in_b};
    sub_sum = {1'b0, in_a} + {1'b0, ~in_b} + WP1'(1);
    s_res   = '0;
    s_flags = '0;
    case (in_op)
      ALU_ADD: begin
        s_res            = add_sum[WIDTH-1:0];
        s_flags.carry    = add_sum[WIDTH];
        s_flags.overflow = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (add_sum[WIDTH-1] != in_a[WIDTH-1]);
      end
      ALU_SUB: begin
        s_res            = sub_sum[WIDTH-1:0];
        s_flags.carry    = sub_sum[WIDTH];
        s_flags.overflow = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (sub_sum[WIDTH-1] != in_a[WIDTH-1]);
      end
      ALU_NOT:  s_res = ~in_a;
      ALU_AND:  s_res = in_a & in_b;
      ALU_OR:   s_res = in_a | in_b;
      ALU_XOR:  s_res = in_a ^ in_b;
      ALU_SLT:  s_res = WIDTH'($signed(in_a) < $signed(in_b));
      ALU_EQ:   s_res = WIDTH'(in_a == in_b);
      ALU_SLTU: s_res = WIDTH'(in_a < in_b);
      ALU_MUL, ALU_DIVU, ALU_REMU: ;
      default:  s_flags.illegal = 1'b1;
    endcase
    s_flags.zero = (s_res == '0);
  end

  // Iterative results, with the divide-by-zero conventions applied on the latched operands.
  always_comb begin
    m_res   = md_lo;
    m_flags = '0;
    case (op_q)
      ALU_MUL: m_flags.overflow = (md_hi != '0);
      ALU_DIVU: begin
        if (b_q == '0) begin
          m_res            = '1;
          m_flags.overflow = 1'b1;
        end
      end
      ALU_REMU: begin
        m_res = md_hi;
        if (b_q == '0) begin
          m_res            = a_q;
          m_flags.overflow = 1'b1;
        end
      end
      default: ;
    endcase
    m_flags.zero = (m_res == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = is_muldiv(in_op) ? S_CALC : S_DONE;
      S_CALC:  if (done_c) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values for the output registers; everything holds unless a transition updates it.
  always_comb begin
    res_d   = out_res;
    flags_d = flags_q;
    valid_d = out_valid;
    ready_d = in_ready;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          ready_d = 1'b0;
          if (!is_muldiv(in_op)) begin
            res_d   = s_res;
            flags_d = s_flags;
            valid_d = 1'b1;
          end
        end
      end
      S_CALC: begin
        if (done_c) begin
          res_d   = m_res;
          flags_d = m_flags;
          valid_d = 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          valid_d = 1'b0;
          ready_d = 1'b1;
        end
      end
      default: begin
        valid_d = 1'b0;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_res   <= '0;
      flags_q   <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
    end else begin
      out_res   <= res_d;
      flags_q   <= flags_d;
      out_valid <= valid_d;
      in_ready  <= ready_d;
      if (accept) begin
        op_q <= in_op;
        a_q  <= in_a;
        b_q  <= in_b;
      end
    end
  end

  assign out_zero     = flags_q.zero;
  assign out_overflow = flags_q.overflow;
  assign out_carry    = flags_q.carry;
  assign out_illegal  = flags_q.illegal;

endmodule
